// File: rtl/my_io_pkg.sv
// rtl/my_io_pkg.sv - shared encodings and defaults for the serial input port
package my_io_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   localparam int DEF_CLKS_PER_BIT = 16;
   localparam int DEF_DATA_W       = 8;

endpackage

// File: rtl/my_sync2.sv
// rtl/my_sync2.sv - two-flop synchroniser, resets to the idle-high line level
module my_sync2 (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/my_input_port.sv
// rtl/my_input_port.sv - 8N1 receiver loading INPR and raising FGI for the Basic Computer
module my_input_port
   import my_io_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_W       = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx,
   input  logic              clr_fgi,
   input  logic              clr_err,
   output logic [DATA_W-1:0] inpr,
   output logic              fgi,
   output logic              ovr,
   output logic              ferr,
   output logic              busy
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W  = $clog2(DATA_W);

   rx_state_t         state, state_nxt;
   logic              rx_s;
   logic [BAUD_W-1:0] baud_cnt;
   logic [IDX_W-1:0]  bit_idx;
   logic [DATA_W-1:0] shift;
   logic              baud_half, baud_full, last_bit;
   logic              frame_ok, frame_bad;
   logic              load, ovr_set;

   my_sync2 u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (rx),
      .q       (rx_s)
   );

   assign baud_half = (baud_cnt == BAUD_W'(CLKS_PER_BIT/2 - 1));
   assign baud_full = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
   assign last_bit  = (bit_idx  == IDX_W'(DATA_W - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      frame_ok  = 1'b0;
      frame_bad = 1'b0;
      case (state)
         IDLE:  if (!rx_s) state_nxt = START;
         START: if (baud_half) state_nxt = rx_s ? IDLE : DATA;
         DATA:  if (baud_full && last_bit) state_nxt = STOP;
         STOP: begin
            if (baud_full) begin
               state_nxt = IDLE;
               frame_ok  = rx_s;
               frame_bad = !rx_s;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The half-bit wait in START re-centres every later sample mid-bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         if (state == IDLE || (state == START && baud_half) || baud_full)
            baud_cnt <= '0;
         else
            baud_cnt <= baud_cnt + BAUD_W'(1);

         if (state != DATA)
            bit_idx <= '0;
         else if (baud_full)
            bit_idx <= bit_idx + IDX_W'(1);

         if (state == DATA && baud_full)
            shift[bit_idx] <= rx_s;
      end
   end

   // A same-cycle INP consumes the old character, so the new one may load.
   assign load    = frame_ok && (!fgi || clr_fgi);
   assign ovr_set = frame_ok && fgi && !clr_fgi;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inpr <= '0;
         fgi  <= 1'b0;
         ovr  <= 1'b0;
         ferr <= 1'b0;
      end else begin
         if (load) inpr <= shift;

         if (load)         fgi <= 1'b1;
         else if (clr_fgi) fgi <= 1'b0;

         if (ovr_set)      ovr <= 1'b1;
         else if (clr_err) ovr <= 1'b0;

         if (frame_bad)    ferr <= 1'b1;
         else if (clr_err) ferr <= 1'b0;
      end
   end

   assign busy = (state != IDLE);

endmodule
